// File: rtl/rram_pkg.sv
// rram_pkg: shared state encoding, default geometry and width helpers for the RRAM programmer
package rram_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, RECOVER, VERIFY} state_t;
  localparam int DEF_HEIGHT = 512;
  localparam int DEF_WIDTH = 512;
  localparam int DEF_WORD = 8;
  localparam int DEF_PULSE = 4;
  localparam int DEF_RECOVER = 2;
  localparam int DEF_RETRIES = 3;
  function automatic int addr_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
  function automatic int cnt_width(input int p, input int r);
    return $clog2((p > r ? p : r) + 1);
  endfunction
endpackage

// File: rtl/rram_pulse_timer.sv
// rram_pulse_timer: loadable down-counter; done is high on the last cycle of a loaded interval
//  clk, rst      clock, async active-high reset
//  load          load load_val this cycle (the interval starts next cycle)
//  load_val      interval length in cycles, >=1
//  done          high while the count is 1, i.e. the final cycle of the interval
module rram_pulse_timer
  import rram_pkg::*;
#(
  parameter int CNT_W = cnt_width(DEF_PULSE, DEF_RECOVER)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             done
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? load_val : (cnt_q != '0 ? cnt_q - CNT_W'(1) : cnt_q);
  assign done = cnt_q == CNT_W'(1);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/rram_matrix_programmer.sv
// rram_matrix_programmer: programs RRAM crossbar cells from (row, col, weight) host beats with timed write pulses
//  in_valid/in_ready/in_row/in_col/in_data   host beat handshake; in_ready = idle & dotp_idle
//  dotp_idle                                 no new cell is started while the dot-product engine is active
//  cell_wr_en/cell_row/cell_col/cell_data    crossbar write port, registered
//  cell_rd_data                              read-back used only when RRAM_WRITE_VERIFY_EN is defined
//  busy, err (sticky), prog_count (wrapping) status
//  Build option: RRAM_WRITE_VERIFY_EN adds a read-back VERIFY step with up to MAX_RETRIES re-pulses.
module rram_matrix_programmer
  import rram_pkg::*;
#(
  parameter int RRAM_DOTP_HEIGHT   = DEF_HEIGHT,
  parameter int RRAM_DOTP_WIDTH    = DEF_WIDTH,
  parameter int WORD_SIZE_MATRIX   = DEF_WORD,
  parameter int WRITE_PULSE_CYCLES = DEF_PULSE,
  parameter int RECOVER_CYCLES     = DEF_RECOVER,
  parameter int MAX_RETRIES        = DEF_RETRIES,
  localparam int ROW_W = addr_width(RRAM_DOTP_HEIGHT),
  localparam int COL_W = addr_width(RRAM_DOTP_WIDTH)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [ROW_W-1:0]            in_row,
  input  logic [COL_W-1:0]            in_col,
  input  logic [WORD_SIZE_MATRIX-1:0] in_data,
  input  logic                        dotp_idle,
  output logic                        cell_wr_en,
  output logic [ROW_W-1:0]            cell_row,
  output logic [COL_W-1:0]            cell_col,
  output logic [WORD_SIZE_MATRIX-1:0] cell_data,
  input  logic [WORD_SIZE_MATRIX-1:0] cell_rd_data,
  output logic                        busy,
  output logic                        err,
  output logic [31:0]                 prog_count
);
  localparam int CNT_W = cnt_width(WRITE_PULSE_CYCLES, RECOVER_CYCLES);
  state_t state_q, state_d;
  logic wr_en_q, wr_en_d, busy_q, busy_d, err_q, err_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [WORD_SIZE_MATRIX-1:0] data_q, data_d;
  logic [31:0] count_q, count_d;
  logic xfer, row_bad, col_bad, tmr_load, tmr_done;
  logic [CNT_W-1:0] tmr_val;
  assign in_ready = (state_q == IDLE) & dotp_idle;
  assign xfer = in_valid & in_ready;
  // Power-of-2 dimensions can never be out of range, so no compare is built for them.
  if ((1 << ROW_W) == RRAM_DOTP_HEIGHT) begin : g_row_full
    assign row_bad = 1'b0;
  end else begin : g_row_chk
    assign row_bad = in_row > ROW_W'(RRAM_DOTP_HEIGHT - 1);
  end
  if ((1 << COL_W) == RRAM_DOTP_WIDTH) begin : g_col_full
    assign col_bad = 1'b0;
  end else begin : g_col_chk
    assign col_bad = in_col > COL_W'(RRAM_DOTP_WIDTH - 1);
  end
  // One timer serves both intervals: SETUP arms the pulse, the last pulse cycle arms recovery.
  assign tmr_load = (state_q == SETUP) | ((state_q == PULSE) & tmr_done);
  assign tmr_val = state_q == SETUP ? CNT_W'(WRITE_PULSE_CYCLES) : CNT_W'(RECOVER_CYCLES);
  rram_pulse_timer #(.CNT_W(CNT_W)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .done     (tmr_done)
  );
`ifdef RRAM_WRITE_VERIFY_EN
  localparam int RETRY_W = addr_width(MAX_RETRIES + 1);
  logic [RETRY_W-1:0] retry_q, retry_d;
`else
  logic unused_rd;
  assign unused_rd = ^{cell_rd_data, 32'(MAX_RETRIES)};
`endif
  always_comb begin
    state_d = state_q;
    row_d = row_q;
    col_d = col_q;
    data_d = data_q;
    count_d = count_q;
    err_d = err_q;
`ifdef RRAM_WRITE_VERIFY_EN
    retry_d = retry_q;
`endif
    case (state_q)
      IDLE: if (xfer) begin
        if (row_bad | col_bad) err_d = 1'b1;
        else begin
          state_d = SETUP;
          row_d = in_row;
          col_d = in_col;
          data_d = in_data;
`ifdef RRAM_WRITE_VERIFY_EN
          retry_d = '0;
`endif
        end
      end
      SETUP: state_d = PULSE;
      PULSE: state_d = tmr_done ? RECOVER : PULSE;
      RECOVER: if (tmr_done) begin
`ifdef RRAM_WRITE_VERIFY_EN
        state_d = VERIFY;
`else
        state_d = IDLE;
        count_d = count_q + 32'd1;
`endif
      end
`ifdef RRAM_WRITE_VERIFY_EN
      VERIFY: begin
        state_d = IDLE;
        if (cell_rd_data == data_q) count_d = count_q + 32'd1;
        else if (retry_q < RETRY_W'(MAX_RETRIES)) begin
          retry_d = retry_q + RETRY_W'(1);
          state_d = SETUP;
        end else err_d = 1'b1;
      end
`endif
      default: state_d = IDLE;
    endcase
    wr_en_d = state_d == PULSE;
    busy_d = state_d != IDLE;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wr_en_q <= 1'b0;
      busy_q <= 1'b0;
      err_q <= 1'b0;
      row_q <= '0;
      col_q <= '0;
      data_q <= '0;
      count_q <= '0;
`ifdef RRAM_WRITE_VERIFY_EN
      retry_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      wr_en_q <= wr_en_d;
      busy_q <= busy_d;
      err_q <= err_d;
      row_q <= row_d;
      col_q <= col_d;
      data_q <= data_d;
      count_q <= count_d;
`ifdef RRAM_WRITE_VERIFY_EN
      retry_q <= retry_d;
`endif
    end
  end
  assign cell_wr_en = wr_en_q;
  assign cell_row = row_q;
  assign cell_col = col_q;
  assign cell_data = data_q;
  assign busy = busy_q;
  assign err = err_q;
  assign prog_count = count_q;
endmodule

// File: tb/tb_rram_matrix_programmer.sv
// tb_rram_matrix_programmer: timeline model of the programmer plus directed and random host traffic
module tb_rram_matrix_programmer;
  localparam int H = 500;
  localparam int W = 512;
  localparam int P = 4;
  localparam int R = 2;
  localparam int MAXR = 3;
`ifdef RRAM_WRITE_VERIFY_EN
  localparam int VX = 1;
`else
  localparam int VX = 0;
`endif
  localparam int L = P + R + 1 + VX;
  logic clk = 0, rst = 1, in_valid = 0, dotp_idle = 1;
  logic in_ready, cell_wr_en, busy, err;
  logic [8:0] in_row = 0, in_col = 0, cell_row, cell_col;
  logic [7:0] in_data = 0, cell_data, m_rd = 0;
  logic [31:0] prog_count;
  int n_chk = 0, n_fail = 0, cyc = 0, mism_cfg = 0;
  int unsigned m_count = 0;
  bit m_err = 0, op_active = 0, op_ok = 0, m_xfer = 0;
  int op_t = 0, op_mism = 0, m_free = 0;
  logic [8:0] m_row = 0, m_col = 0;
  logic [7:0] m_data = 0;
  rram_matrix_programmer #(.RRAM_DOTP_HEIGHT(H), .RRAM_DOTP_WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_row(in_row),
    .in_col(in_col), .in_data(in_data), .dotp_idle(dotp_idle), .cell_wr_en(cell_wr_en),
    .cell_row(cell_row), .cell_col(cell_col), .cell_data(cell_data), .cell_rd_data(m_rd),
    .busy(busy), .err(err), .prog_count(prog_count)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    #2 rst = 1;
    in_valid = 0;
    @(negedge clk);
    #1 rst = 0;
    tick();
  endtask
  // Each accepted cell occupies L cycles per attempt starting the cycle after acceptance;
  // within an attempt, offsets 1..P carry the write pulse. Results land when the op ends.
  always @(negedge clk) begin
    if (rst) begin
      m_count = 0; m_err = 0; op_active = 0; m_xfer = 0;
      m_row = 0; m_col = 0; m_data = 0;
    end else begin : mdl
      int rel;
      if (op_active && cyc >= m_free) begin
        if (op_ok) m_count++;
        else m_err = 1;
        op_active = 0;
      end
      rel = cyc - op_t - 1;
      chk("ready", in_ready, !op_active && dotp_idle);
      chk("busy", busy, op_active);
      chk("wr_en", cell_wr_en, op_active && (rel % L) >= 1 && (rel % L) <= P);
      chk("err", err, m_err);
      chk("prog_count", prog_count, m_count);
      chk("cell_row", cell_row, m_row);
      chk("cell_col", cell_col, m_col);
      chk("cell_data", cell_data, m_data);
      if (op_active) m_rd = (rel / L < op_mism) ? ~m_data : m_data;
      m_xfer = in_valid && !op_active && dotp_idle;
      if (m_xfer) begin
        op_active = 1;
        op_t = cyc;
        if (int'(in_row) >= H || int'(in_col) >= W) begin
          op_ok = 0;
          m_free = cyc + 1;
        end else begin
          op_mism = VX ? mism_cfg : 0;
          op_ok = op_mism <= MAXR;
          m_free = cyc + 1 + ((op_mism > MAXR ? MAXR : op_mism) + 1) * L;
          m_row = in_row; m_col = in_col; m_data = in_data;
        end
      end
    end
  end
  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int acc_n;
    int acc_c[4];
    bit got, prev;
    int pulses;
    repeat (2) @(negedge clk);
    chk("rst_wr", cell_wr_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_count", prog_count, 0);
    chk("rst_data", cell_data, 0);
    #1 rst = 0;
    tick();
    // single beat
    in_valid = 1; in_row = 3; in_col = 7; in_data = 8'hA5;
    @(negedge clk);
    chk("t1_ready0", in_ready, 1);
    tick();
    in_valid = 0;
    for (int k = 1; k <= 8 + VX; k++) begin
      if (k > 1) tick();
      @(negedge clk);
      chk("t1_wr", cell_wr_en, k >= 2 && k <= 5);
      chk("t1_rdy", in_ready, k == 8 + VX);
    end
    chk("t1_count", prog_count, 1);
    chk("t1_row", cell_row, 3);
    chk("t1_col", cell_col, 7);
    chk("t1_data", cell_data, 8'hA5);
    tick();
    // async reset in the third pulse cycle
    in_valid = 1; in_row = 1; in_col = 2; in_data = 8'h3C;
    tick();
    in_valid = 0;
    repeat (3) tick();
    chk("t4_pulse_on", cell_wr_en, 1);
    #2 rst = 1;
    #1;
    chk("t4_wr", cell_wr_en, 0);
    chk("t4_busy", busy, 0);
    chk("t4_count", prog_count, 0);
    chk("t4_err", err, 0);
    @(negedge clk);
    #1 rst = 0;
    tick();
    // dotp_idle gating
    dotp_idle = 0; in_valid = 1; in_row = 10; in_col = 20; in_data = 8'h11;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t3_stall_rdy", in_ready, 0);
      chk("t3_stall_wr", cell_wr_en, 0);
      tick();
    end
    dotp_idle = 1;
    @(negedge clk);
    chk("t3_acc", in_ready, 1);
    tick();
    in_row = 11; in_col = 21; in_data = 8'h22;
    tick();
    tick();
    dotp_idle = 0;
    for (int k = 3; k <= 10 + VX; k++) begin
      @(negedge clk);
      chk("t3_wr", cell_wr_en, k >= 3 && k <= 5);
      chk("t3_rdy", in_ready, 0);
      tick();
    end
    @(negedge clk);
    chk("t3_count1", prog_count, 1);
    dotp_idle = 1;
    #1;
    chk("t3_resume", in_ready, 1);
    tick();
    in_valid = 0;
    repeat (L + 1) tick();
    @(negedge clk);
    chk("t3_count2", prog_count, 2);
    tick();
    // back-to-back beats
    acc_n = 0;
    in_valid = 1; in_row = 20; in_col = 40; in_data = 8'h30;
    for (int k = 0; k < 80 && acc_n < 4; k++) begin
      @(negedge clk);
      got = in_ready;
      if (got) begin
        acc_c[acc_n] = cyc;
        acc_n++;
      end
      tick();
      if (got) begin
        if (acc_n < 4) begin
          in_row = 9'(20 + acc_n); in_col = 9'(40 + acc_n); in_data = 8'(8'h30 + acc_n);
        end else in_valid = 0;
      end
    end
    chk("t2_accepts", acc_n, 4);
    for (int i = 1; i < acc_n; i++) chk("t2_spacing", acc_c[i] - acc_c[i-1], 8 + VX);
    repeat (L + 1) tick();
    @(negedge clk);
    chk("t2_count", prog_count, 6);
    chk("t2_last", cell_data, 8'h33);
    tick();
    // out-of-range row
    in_valid = 1; in_row = 9'd510; in_col = 5; in_data = 8'h77;
    @(negedge clk);
    chk("t5_acc", in_ready, 1);
    tick();
    in_row = 9'd499; in_col = 9'd511; in_data = 8'h5A;
    @(negedge clk);
    chk("t5_err", err, 1);
    chk("t5_ready", in_ready, 1);
    chk("t5_busy", busy, 0);
    chk("t5_wr", cell_wr_en, 0);
    chk("t5_count", prog_count, 6);
    tick();
    in_valid = 0;
    repeat (L + 1) tick();
    @(negedge clk);
    chk("t5_count2", prog_count, 7);
    chk("t5_sticky", err, 1);
    chk("t5_row", cell_row, 499);
    tick();
`ifdef RRAM_WRITE_VERIFY_EN
    for (int t = 0; t < 2; t++) begin
      do_reset();
      mism_cfg = t == 0 ? 2 : MAXR + 1;
      in_valid = 1; in_row = 4; in_col = 4; in_data = 8'h99;
      @(negedge clk);
      chk("t6_acc", in_ready, 1);
      tick();
      in_valid = 0;
      pulses = 0;
      prev = 0;
      for (int k = 0; k < 4 * L + 4; k++) begin
        @(negedge clk);
        if (cell_wr_en && !prev) pulses++;
        prev = cell_wr_en;
        tick();
      end
      chk("t6_pulses", pulses, t == 0 ? 3 : 4);
      chk("t6_err", err, t);
      chk("t6_count", prog_count, t == 0 ? 1 : 0);
    end
`endif
    // random traffic
    for (int k = 0; k < 600; k++) begin
      dotp_idle = $urandom_range(0, 7) != 0;
      if (!in_valid || m_xfer) begin
        in_valid = $urandom_range(0, 2) != 0;
        in_row = $urandom_range(0, 9) == 0 ? 9'(500 + $urandom_range(0, 11)) : 9'($urandom_range(0, 499));
        in_col = 9'($urandom_range(0, 511));
        in_data = 8'($urandom);
        mism_cfg = $urandom_range(0, MAXR + 1);
      end
      tick();
    end
    in_valid = 0;
    dotp_idle = 1;
    repeat (5 * L) tick();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
